qeciphy_tx_arbiter: RTL and testbench



---
 rtl/qeciphy_tx_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_qeciphy_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qeciphy_tx_arbiter.sv
// -----------------------------------------------------------------------------
// qeciphy_tx_arbiter
//
// Shares one QECIPHY TX AXI-Stream link between N_REQ local requesters.
// Round-robin arbitration with a bounded burst length (MAX_BURST beats per
// grant). Grants are issued only while the PHY reports link-up. The output
// beat is registered, giving a timing break in front of the PHY.
//
// Ports:
//   ACLK         clock (QECIPHY ACLK domain)
//   ARST         asynchronous, active-high reset
//   LINK_STATUS  QECIPHY STATUS; link is up when equal to LINK_UP_CODE
//   S_TDATA      requester data, requester i on [i*DATA_W +: DATA_W]
//   S_TVALID     per-requester valid
//   S_TREADY     per-requester ready (combinational, at most one bit high)
//   M_TDATA      to QECIPHY TX_TDATA (registered)
//   M_TVALID     to QECIPHY TX_TVALID (registered)
//   M_TREADY     from QECIPHY TX_TREADY
//   GRANT        one-hot current owner, all zero when nobody owns the link
//   BUSY         high while a burst is in progress
//
// Optional feature (compile-time macro QECIPHY_ARB_ID_TAG_EN):
//   When defined, the top clog2(N_REQ) bits of each captured beat are
//   overwritten with the owner index so the far end can demultiplex.
//   When undefined, data passes through unmodified.
// -----------------------------------------------------------------------------
module qeciphy_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned MAX_BURST    = 16,
    parameter logic [3:0]  LINK_UP_CODE = 4'b0100
) (
    input  logic                      ACLK,
    input  logic                      ARST,
    input  logic [3:0]                LINK_STATUS,
    input  logic [N_REQ*DATA_W-1:0]   S_TDATA,
    input  logic [N_REQ-1:0]          S_TVALID,
    output logic [N_REQ-1:0]          S_TREADY,
    output logic [DATA_W-1:0]         M_TDATA,
    output logic                      M_TVALID,
    input  logic                      M_TREADY,
    output logic [N_REQ-1:0]          GRANT,
    output logic                      BUSY
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        LINKDOWN,
        IDLE,
        BURST
    } state_t;

    state_t             state_q, state_d;
    logic               link_up_q;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               m_tvalid_q;
    logic [DATA_W-1:0]  m_tdata_q;

    logic               out_free;
    logic               accept;
    logic [CNT_W-1:0]   beat_inc;
    logic [IDX_W-1:0]   next_ptr;
    logic [DATA_W-1:0]  owner_data;
    logic [DATA_W-1:0]  capture_data;

    // Round-robin search results
    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand_idx;
    int unsigned        cand;

    // -------------------------------------------------------------------------
    // Handshake and datapath helpers
    // -------------------------------------------------------------------------
    assign out_free   = !m_tvalid_q || M_TREADY;
    assign S_TREADY   = (state_q == BURST && link_up_q && out_free) ? grant_q : '0;
    assign accept     = S_TVALID[owner_q] && S_TREADY[owner_q];
    assign beat_inc   = beat_cnt_q + 1'b1;
    assign next_ptr   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_data = S_TDATA[owner_q*DATA_W +: DATA_W];

`ifdef QECIPHY_ARB_ID_TAG_EN
    always_comb begin
        capture_data = owner_data;
        capture_data[DATA_W-1 -: IDX_W] = owner_q;
    end
`else
    assign capture_data = owner_data;
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_q    <= LINKDOWN;
            link_up_q  <= 1'b0;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            link_up_q  <= (LINK_STATUS == LINK_UP_CODE);
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin search: first valid requester at or after rr_ptr, wrapping
    // -------------------------------------------------------------------------
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && S_TVALID[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;

        case (state_q)
            LINKDOWN: begin
                grant_d = '0;
                if (link_up_q) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (!link_up_q) begin
                    state_d = LINKDOWN;
                end else if (found) begin
                    for (int unsigned k = 0; k < N_REQ; k++) begin
                        grant_d[k] = (IDX_W'(k) == pick);
                    end
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end

            BURST: begin
                if (accept) begin
                    beat_cnt_d = beat_inc;
                end
                // Link loss takes priority over budget exhaustion; a beat
                // accepted this cycle is already in the output register.
                if (!link_up_q) begin
                    state_d  = LINKDOWN;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end else if ((accept && beat_inc == CNT_W'(MAX_BURST)) ||
                             (!S_TVALID[owner_q] && out_free)) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
            end

            default: begin
                state_d = LINKDOWN;
                grant_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output register: holds a valid beat stable until the PHY takes it,
    // independent of link state.
    // -------------------------------------------------------------------------
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
        end else if (accept) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= capture_data;
        end else if (M_TREADY) begin
            m_tvalid_q <= 1'b0;
        end
    end

    assign M_TVALID = m_tvalid_q;
    assign M_TDATA  = m_tdata_q;
    assign GRANT    = grant_q;
    assign BUSY     = (state_q == BURST);

endmodule

// File: tb/tb_qeciphy_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qeciphy_tx_arbiter
//
// Directed bench for qeciphy_tx_arbiter (N_REQ=4, DATA_W=64, MAX_BURST=16).
// Each requester is a simple counter-driven source: requester i offers
// base[i] + cnt[i] while enabled and cnt[i] < limit[i], advancing on its
// own handshake. Per-cycle traces of the outputs are captured after each
// clock edge and compared against hand-derived timing.
// -----------------------------------------------------------------------------
module tb_qeciphy_tx_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    logic           ACLK;
    logic           ARST;
    logic [3:0]     LINK_STATUS;
    logic [N*W-1:0] S_TDATA;
    logic [N-1:0]   S_TVALID;
    logic [N-1:0]   S_TREADY;
    logic [W-1:0]   M_TDATA;
    logic           M_TVALID;
    logic           M_TREADY;
    logic [N-1:0]   GRANT;
    logic           BUSY;

    int checks = 0;
    int errors = 0;

    // requester models
    logic [W-1:0] base  [0:N-1];
    int           cnt   [0:N-1];
    int           limit [0:N-1];
    logic         en    [0:N-1];

    // traces: tr_* sampled after edge n, tr_sr sampled before edge n
    logic         tr_v  [0:127];
    logic [W-1:0] tr_d  [0:127];
    logic [N-1:0] tr_g  [0:127];
    logic [N-1:0] tr_sr [0:127];
    logic [W-1:0] taken_q [$];

    qeciphy_tx_arbiter #(
        .N_REQ        (N),
        .DATA_W       (W),
        .MAX_BURST    (16),
        .LINK_UP_CODE (4'b0100)
    ) dut (
        .ACLK        (ACLK),
        .ARST        (ARST),
        .LINK_STATUS (LINK_STATUS),
        .S_TDATA     (S_TDATA),
        .S_TVALID    (S_TVALID),
        .S_TREADY    (S_TREADY),
        .M_TDATA     (M_TDATA),
        .M_TVALID    (M_TVALID),
        .M_TREADY    (M_TREADY),
        .GRANT       (GRANT),
        .BUSY        (BUSY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Expected M_TDATA for a beat from a given owner (top bits carry the
    // owner index when tagging is compiled in).
    function automatic logic [W-1:0] exp_d(input logic [W-1:0] d, input int owner);
        logic [W-1:0] r;
        logic [1:0]   o;
        r = d;
        o = 2'(owner);
`ifdef QECIPHY_ARB_ID_TAG_EN
        r[W-1 -: 2] = o;
`endif
        return r;
    endfunction

    // One clock: drive requester inputs, sample pre-edge, step past the edge.
    task automatic cycle(input int n);
        logic [N-1:0] hs;
        for (int i = 0; i < N; i++) begin
            S_TVALID[i] = en[i] && (cnt[i] < limit[i]);
            S_TDATA[i*W +: W] = base[i] + W'(cnt[i]);
        end
        #1;
        hs = S_TVALID & S_TREADY;
        if (n >= 0) tr_sr[n] = S_TREADY;
        if (M_TVALID && M_TREADY) taken_q.push_back(M_TDATA);
        @(posedge ACLK);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) cnt[i]++;
        end
        if (n >= 0) begin
            tr_v[n] = M_TVALID;
            tr_d[n] = M_TDATA;
            tr_g[n] = GRANT;
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            en[i]    = 1'b0;
            cnt[i]   = 0;
            limit[i] = 0;
            base[i]  = '0;
        end
        taken_q.delete();
    endtask

    // Reset and let the link come up; leaves the DUT in IDLE with rr_ptr=0.
    task automatic do_reset();
        ARST        = 1'b1;
        M_TREADY    = 1'b1;
        LINK_STATUS = 4'b0100;
        clear_reqs();
        repeat (2) cycle(-1);
        ARST = 1'b0;
        repeat (3) cycle(-1);
    endtask

    task automatic test_reset();
        ARST        = 1'b1;
        M_TREADY    = 1'b1;
        LINK_STATUS = 4'b0100;
        clear_reqs();
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b1; limit[i] = 100; base[i] = W'(i) << 16;
        end
        repeat (5) cycle(-1);
        checks++; if (M_TVALID !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b expected 0", M_TVALID); end
        checks++; if (M_TDATA !== '0) begin errors++; $display("FAIL reset_m_tdata: got %h expected 0", M_TDATA); end
        checks++; if (GRANT !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", GRANT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        checks++; if (S_TREADY !== '0) begin errors++; $display("FAIL reset_s_tready: got %b expected 0000", S_TREADY); end
        ARST = 1'b0;
        for (int n = 0; n < 5; n++) cycle(n);
        checks++; if (tr_g[0] !== 4'b0000) begin errors++; $display("FAIL reset_grant_c1: got %b expected 0000", tr_g[0]); end
        checks++; if (tr_g[1] !== 4'b0000) begin errors++; $display("FAIL reset_grant_c2: got %b expected 0000", tr_g[1]); end
        checks++; if (tr_g[2] !== 4'b0001) begin errors++; $display("FAIL reset_grant_c3: got %b expected 0001", tr_g[2]); end
        checks++; if (tr_v[4] !== 1'b1 || tr_d[4] !== exp_d(64'h1, 0)) begin
            errors++; $display("FAIL reset_first_beats: got v=%b d=%h expected v=1 d=%h", tr_v[4], tr_d[4], exp_d(64'h1, 0));
        end
        // asynchronous reset in the middle of a burst
        #2;
        ARST = 1'b1;
        #1;
        checks++; if (M_TVALID !== 1'b0 || GRANT !== '0 || BUSY !== 1'b0 || M_TDATA !== '0) begin
            errors++; $display("FAIL arst_midburst: got v=%b g=%b busy=%b d=%h expected all 0", M_TVALID, GRANT, BUSY, M_TDATA);
        end
    endtask

    task automatic test_single();
        do_reset();
        en[0] = 1'b1; limit[0] = 20; base[0] = '0;
        for (int n = 0; n < 24; n++) cycle(n);
        checks++; if (tr_g[0] !== 4'b0001) begin errors++; $display("FAIL single_grant0: got %b expected 0001", tr_g[0]); end
        for (int n = 1; n <= 16; n++) begin
            checks++;
            if (tr_v[n] !== 1'b1 || tr_d[n] !== exp_d(W'(n - 1), 0)) begin
                errors++; $display("FAIL single_beat%0d: got v=%b d=%h expected v=1 d=%h", n - 1, tr_v[n], tr_d[n], exp_d(W'(n - 1), 0));
            end
        end
        checks++; if (tr_g[15] !== 4'b0001) begin errors++; $display("FAIL single_grant_hold: got %b expected 0001", tr_g[15]); end
        checks++; if (tr_g[16] !== 4'b0000) begin errors++; $display("FAIL single_grant_release: got %b expected 0000", tr_g[16]); end
        checks++; if (tr_v[17] !== 1'b0) begin errors++; $display("FAIL single_bubble: got v=%b expected 0", tr_v[17]); end
        checks++; if (tr_g[17] !== 4'b0001) begin errors++; $display("FAIL single_regrant: got %b expected 0001", tr_g[17]); end
        for (int n = 18; n <= 21; n++) begin
            checks++;
            if (tr_v[n] !== 1'b1 || tr_d[n] !== exp_d(W'(n - 2), 0)) begin
                errors++; $display("FAIL single_beat%0d: got v=%b d=%h expected v=1 d=%h", n - 2, tr_v[n], tr_d[n], exp_d(W'(n - 2), 0));
            end
        end
        checks++; if (tr_v[22] !== 1'b0 || tr_g[22] !== 4'b0000) begin
            errors++; $display("FAIL single_owner_idle: got v=%b g=%b expected v=0 g=0000", tr_v[22], tr_g[22]);
        end
    endtask

    task automatic test_contention();
        int owner;
        logic [W-1:0] e;
        do_reset();
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b1; limit[i] = 100; base[i] = W'(i) << 16;
        end
        for (int n = 0; n < 86; n++) cycle(n);
        for (int k = 0; k < 5; k++) begin
            owner = k % 4;
            if (k > 0) begin
                checks++;
                if (tr_v[17*k] !== 1'b0) begin errors++; $display("FAIL contention_gap%0d: got v=%b expected 0", k, tr_v[17*k]); end
            end
            checks++;
            if (tr_g[17*k] !== (4'b0001 << owner)) begin
                errors++; $display("FAIL contention_grant%0d: got %b expected %b", k, tr_g[17*k], 4'b0001 << owner);
            end
            for (int j = 0; j < 16; j++) begin
                e = exp_d((W'(owner) << 16) + W'((k / 4) * 16 + j), owner);
                checks++;
                if (tr_v[17*k+1+j] !== 1'b1 || tr_d[17*k+1+j] !== e) begin
                    errors++; $display("FAIL contention_g%0d_b%0d: got v=%b d=%h expected v=1 d=%h", k, j, tr_v[17*k+1+j], tr_d[17*k+1+j], e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        en[0] = 1'b1; limit[0] = 20; base[0] = 64'h100;
        for (int n = 0; n < 24; n++) begin
            M_TREADY = !(n >= 5 && n <= 9);
            cycle(n);
        end
        M_TREADY = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            checks++;
            if (tr_d[n] !== exp_d(64'h100 + W'(n - 1), 0)) begin
                errors++; $display("FAIL bp_pre%0d: got %h expected %h", n, tr_d[n], exp_d(64'h100 + W'(n - 1), 0));
            end
        end
        for (int n = 5; n <= 9; n++) begin
            checks++;
            if (tr_v[n] !== 1'b1 || tr_d[n] !== exp_d(64'h103, 0) || tr_sr[n] !== 4'b0000) begin
                errors++; $display("FAIL bp_stall%0d: got v=%b d=%h sready=%b expected v=1 d=%h sready=0000",
                                   n, tr_v[n], tr_d[n], tr_sr[n], exp_d(64'h103, 0));
            end
        end
        for (int n = 10; n <= 21; n++) begin
            checks++;
            if (tr_v[n] !== 1'b1 || tr_d[n] !== exp_d(64'h100 + W'(n - 6), 0)) begin
                errors++; $display("FAIL bp_post%0d: got v=%b d=%h expected v=1 d=%h", n, tr_v[n], tr_d[n], exp_d(64'h100 + W'(n - 6), 0));
            end
        end
        checks++; if (tr_g[20] !== 4'b0001 || tr_g[21] !== 4'b0000) begin
            errors++; $display("FAIL bp_budget: got g20=%b g21=%b expected 0001 0000", tr_g[20], tr_g[21]);
        end
        checks++;
        if (taken_q.size() < 16) begin
            errors++; $display("FAIL bp_taken_count: got %0d expected >=16", taken_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (taken_q[i] !== exp_d(64'h100 + W'(i), 0)) begin
                    errors++; $display("FAIL bp_taken%0d: got %h expected %h", i, taken_q[i], exp_d(64'h100 + W'(i), 0));
                    break;
                end
            end
        end
    endtask

    task automatic test_link_drop();
        do_reset();
        en[1] = 1'b1; limit[1] = 40; base[1] = 64'h1000;
        for (int n = 0; n < 33; n++) begin
            LINK_STATUS = (n >= 7 && n <= 11) ? 4'b0001 : 4'b0100;
            M_TREADY    = !(n >= 8 && n <= 10);
            cycle(n);
        end
        LINK_STATUS = 4'b0100;
        M_TREADY    = 1'b1;
        checks++; if (tr_g[0] !== 4'b0010) begin errors++; $display("FAIL ld_grant: got %b expected 0010", tr_g[0]); end
        checks++; if (tr_v[7] !== 1'b1 || tr_d[7] !== exp_d(64'h1006, 1)) begin
            errors++; $display("FAIL ld_beat7: got v=%b d=%h expected v=1 d=%h", tr_v[7], tr_d[7], exp_d(64'h1006, 1));
        end
        checks++; if (tr_g[8] !== 4'b0000) begin errors++; $display("FAIL ld_grant_drop: got %b expected 0000", tr_g[8]); end
        for (int n = 8; n <= 10; n++) begin
            checks++;
            if (tr_v[n] !== 1'b1 || tr_d[n] !== exp_d(64'h1006, 1) || tr_sr[n] !== 4'b0000) begin
                errors++; $display("FAIL ld_hold%0d: got v=%b d=%h sready=%b expected v=1 d=%h sready=0000",
                                   n, tr_v[n], tr_d[n], tr_sr[n], exp_d(64'h1006, 1));
            end
        end
        checks++; if (tr_v[11] !== 1'b0) begin errors++; $display("FAIL ld_delivered: got v=%b expected 0", tr_v[11]); end
        checks++; if (tr_g[13] !== 4'b0000 || tr_g[14] !== 4'b0010) begin
            errors++; $display("FAIL ld_regrant: got g13=%b g14=%b expected 0000 0010", tr_g[13], tr_g[14]);
        end
        checks++; if (tr_d[15] !== exp_d(64'h1007, 1)) begin
            errors++; $display("FAIL ld_resume: got %h expected %h", tr_d[15], exp_d(64'h1007, 1));
        end
        checks++; if (tr_g[29] !== 4'b0010 || tr_g[30] !== 4'b0000 || tr_d[30] !== exp_d(64'h1016, 1)) begin
            errors++; $display("FAIL ld_fresh_budget: got g29=%b g30=%b d30=%h expected 0010 0000 %h",
                               tr_g[29], tr_g[30], tr_d[30], exp_d(64'h1016, 1));
        end
        checks++;
        if (taken_q.size() < 23) begin
            errors++; $display("FAIL ld_taken_count: got %0d expected >=23", taken_q.size());
        end else begin
            for (int i = 0; i < 23; i++) begin
                if (taken_q[i] !== exp_d(64'h1000 + W'(i), 1)) begin
                    errors++; $display("FAIL ld_taken%0d: got %h expected %h", i, taken_q[i], exp_d(64'h1000 + W'(i), 1));
                    break;
                end
            end
        end
    endtask

    task automatic test_id_tag();
        logic [W-1:0] expect_d;
        do_reset();
        en[2] = 1'b1; limit[2] = 1;
`ifdef QECIPHY_ARB_ID_TAG_EN
        base[2]  = 64'h0;
        expect_d = 64'h8000_0000_0000_0000;
`else
        base[2]  = 64'h0000_0000_0000_00A5;
        expect_d = 64'h0000_0000_0000_00A5;
`endif
        for (int n = 0; n < 3; n++) cycle(n);
        checks++; if (tr_g[0] !== 4'b0100) begin errors++; $display("FAIL tag_grant: got %b expected 0100", tr_g[0]); end
        checks++; if (tr_v[1] !== 1'b1 || tr_d[1] !== expect_d) begin
            errors++; $display("FAIL tag_data: got v=%b d=%h expected v=1 d=%h", tr_v[1], tr_d[1], expect_d);
        end
    endtask

    initial begin
        ARST        = 1'b1;
        M_TREADY    = 1'b1;
        LINK_STATUS = 4'b0100;
        S_TVALID    = '0;
        S_TDATA     = '0;
        clear_reqs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_link_drop();
        test_id_tag();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
